// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall-bus patterns, request struct and priority helpers
// for the pipeline stall controller.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 6;
  typedef logic [CTRL_W-1:0] ctrl_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall vector bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam ctrl_bus_t STALL_NONE = 6'b000000;
  localparam ctrl_bus_t STALL_IF   = 6'b000011;
  localparam ctrl_bus_t STALL_ID   = 6'b000111;
  localparam ctrl_bus_t STALL_EX   = 6'b001111;
  localparam ctrl_bus_t STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] CNT_SAT   = 32'hFFFF_FFFF;

  // Per-stage hold requests, oldest stage in the MSB
  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fe;
  } stall_req_t;

  // Perf counter slot of each source
  typedef enum logic [1:0] {
    SRC_IF  = 2'd0,
    SRC_ID  = 2'd1,
    SRC_EX  = 2'd2,
    SRC_MEM = 2'd3
  } stall_src_e;

  // Oldest requesting stage wins: it and everything older must hold
  function automatic ctrl_bus_t resolve(input stall_req_t r);
    if (r.mem)     return STALL_MEM;
    else if (r.ex) return STALL_EX;
    else if (r.id) return STALL_ID;
    else if (r.fe) return STALL_IF;
    else           return STALL_NONE;
  endfunction

  // Source charged for a stalled cycle; only meaningful when any request is up
  function automatic stall_src_e winner(input stall_req_t r);
    if (r.mem)     return SRC_MEM;
    else if (r.ex) return SRC_EX;
    else if (r.id) return SRC_ID;
    else           return SRC_IF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall request / stall vector / perf bundle between the core
// pipeline (master) and the stall controller (slave).
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        perf_clr;
  ctrl_bus_t   stall;
  logic        wdt_fire;
  logic        wdt_err;
  logic [31:0] cnt_if;
  logic [31:0] cnt_id;
  logic [31:0] cnt_ex;
  logic [31:0] cnt_mem;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, perf_clr,
    input  stall, wdt_fire, wdt_err, cnt_if, cnt_id, cnt_ex, cnt_mem
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, perf_clr,
    output stall, wdt_fire, wdt_err, cnt_if, cnt_id, cnt_ex, cnt_mem
  );

endinterface

// File: rtl/stall_wdt.sv
// stall_wdt: runaway-stall watchdog. Counts consecutive stalled cycles and
// forces a single-cycle release once WDT_LIMIT is reached. WDT_LIMIT = 0
// removes the counter and keeps the release permanently off.
module stall_wdt #(
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic wdt_force,
  output logic wdt_err
);

  generate
    if (WDT_LIMIT == 0) begin : g_off
      assign wdt_force = 1'b0;
      assign wdt_err   = 1'b0;
    end else begin : g_on
      localparam logic [WDT_W-1:0] LAST = WDT_W'(WDT_LIMIT - 1);

      logic [WDT_W-1:0] wdt_cnt;
      logic             force_nxt;

      // Fire after the LIMIT-th consecutive stalled cycle; never twice in a row
      assign force_nxt = active && !wdt_force && (wdt_cnt == LAST);

      // Count stalled cycles; a gap or a forced release restarts the count.
      // The error flag rises together with the first release so it is
      // visible in the same cycle as wdt_fire.
      always_ff @(posedge clk) begin
        if (!rst) begin
          wdt_cnt   <= '0;
          wdt_force <= 1'b0;
          wdt_err   <= 1'b0;
        end else begin
          if (!active || wdt_force) wdt_cnt <= '0;
          else                      wdt_cnt <= wdt_cnt + 1'b1;
          wdt_force <= force_nxt;
          if (force_nxt) wdt_err <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: resolves per-stage stall requests into the 6-bit stall vector,
// applies the watchdog release, and (with STALL_PERF_EN defined) keeps
// saturating per-source stall-cycle counters cleared by perf_clr.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  stall_req_t req;
  ctrl_bus_t  raw;
  logic       active;
  logic       wdt_force;
  logic       wdt_err;

  assign req = '{mem: bus.stallreq_mem, ex: bus.stallreq_ex,
                 id:  bus.stallreq_id,  fe: bus.stallreq_if};

  assign raw    = resolve(req);
  assign active = |raw;

  stall_wdt #(
    .WDT_LIMIT (WDT_LIMIT),
    .WDT_W     (WDT_W)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .active    (active),
    .wdt_force (wdt_force),
    .wdt_err   (wdt_err)
  );

  // Forced release drops every hold for one cycle; otherwise pass raw through
  assign bus.stall    = wdt_force ? STALL_NONE : raw;
  assign bus.wdt_fire = wdt_force;
  assign bus.wdt_err  = wdt_err;

`ifdef STALL_PERF_EN
  logic [3:0][31:0] cnt_q;
  stall_src_e       src;

  assign src = winner(req);

  // Charge each stalled cycle (forced ones included) to the winning source;
  // clear wins over the increment and counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.perf_clr) begin
      cnt_q <= '0;
    end else if (active && (cnt_q[src] != CNT_SAT)) begin
      cnt_q[src] <= cnt_q[src] + 32'd1;
    end
  end

  assign bus.cnt_if  = cnt_q[SRC_IF];
  assign bus.cnt_id  = cnt_q[SRC_ID];
  assign bus.cnt_ex  = cnt_q[SRC_EX];
  assign bus.cnt_mem = cnt_q[SRC_MEM];
`else
  logic perf_clr_unused;
  assign perf_clr_unused = bus.perf_clr;

  assign bus.cnt_if  = ZERO_WORD;
  assign bus.cnt_id  = ZERO_WORD;
  assign bus.cnt_ex  = ZERO_WORD;
  assign bus.cnt_mem = ZERO_WORD;
`endif

endmodule
